// File: rtl/fir_pkg.sv
// Shared types and elaboration-time helpers for the time-multiplexed FIR core.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int SAT_W = 64;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < value) r = i + 1;
    return r;
  endfunction

  // Wide enough that summing TAPS full-precision products can never overflow.
  function automatic int accWidth(input int dataW, input int coefW, input int taps);
    return dataW + coefW + clog2(taps);
  endfunction

  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] acc,
                                                       input int outW);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (outW - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/fir_tdm_core_if.sv
// Sample/coefficient/result bundle between the pad wrapper and the FIR core.
interface fir_tdm_core_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 11
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     coef_load;
  logic                     coef_valid;
  logic signed [COEF_W-1:0] coef_data;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  out_data;
  logic                     busy;

  modport master (
    output in_valid, in_data, coef_load, coef_valid, coef_data,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, coef_load, coef_valid, coef_data,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/fir_mac_unit.sv
// Shared signed multiplier-accumulator, stepped once per tap by the core.
module fir_mac_unit #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 19
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [COEF_W-1:0] b_i,
  output logic signed [ACC_W-1:0]  acc_o
);
  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  acc_q;

  assign product = PROD_W'(a_i) * PROD_W'(b_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc_q <= '0;
    else if (clr_i)
      acc_q <= '0;
    else if (en_i)
      acc_q <= acc_q + ACC_W'(product);
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/fir_tdm_core.sv
// Time-multiplexed N-tap FIR: one MAC walks every tap per sample, with a serial
// coefficient loader, programmable output shift and output saturation.
module fir_tdm_core
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 11,
  parameter int SHIFT  = 0
) (
  input logic           clk,
  input logic           rst_n,
  fir_tdm_core_if.slave bus_if
);
  localparam int ACC_W = accWidth(DATA_W, COEF_W, TAPS);
  localparam int KW    = clog2(TAPS);
  localparam logic [KW-1:0] LAST_K = KW'(TAPS - 1);

  state_t state_q, state_d;
  logic [KW-1:0]            k_q;
  logic signed [DATA_W-1:0] x_q [TAPS];
  logic signed [COEF_W-1:0] c_q [TAPS];
  logic                     outValid_q;
  logic signed [OUT_W-1:0]  outData_q;

  logic inReady, busyInt, macEn, loadIdle, accept;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] accShift;
  logic signed [SAT_W-1:0] accExt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = MAC;
      MAC:     if (k_q == LAST_K) state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A pending coefficient load takes priority over an offered sample.
  always_comb begin
    inReady  = 1'b0;
    busyInt  = 1'b0;
    macEn    = 1'b0;
    loadIdle = 1'b0;
    case (state_q)
      IDLE: begin
        inReady  = rst_n & ~bus_if.coef_load;
        loadIdle = bus_if.coef_load;
      end
      MAC: begin
        macEn   = 1'b1;
        busyInt = 1'b1;
      end
      OUT:     busyInt = 1'b1;
      default: ;
    endcase
  end

  assign accept = bus_if.in_valid & inReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
      end
      c_q[0]     <= COEF_W'(1);
      k_q        <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
    end else begin
      outValid_q <= (state_q == OUT);
      if (state_q == OUT)
        outData_q <= OUT_W'(saturate(accExt, OUT_W));
      // History is flushed while loading so new taps never see old samples.
      if (loadIdle) begin
        for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
        if (bus_if.coef_valid) begin
          for (int i = 0; i < TAPS - 1; i++) c_q[i] <= c_q[i+1];
          c_q[TAPS-1] <= bus_if.coef_data;
        end
      end else if (accept) begin
        for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
        x_q[0] <= bus_if.in_data;
      end
      if (accept)     k_q <= '0;
      else if (macEn) k_q <= k_q + 1'b1;
    end
  end

  fir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (accept),
    .en_i  (macEn),
    .a_i   (x_q[k_q]),
    .b_i   (c_q[k_q]),
    .acc_o (acc)
  );

  assign accShift = acc >>> SHIFT;
  assign accExt   = {{(SAT_W - ACC_W){accShift[ACC_W-1]}}, accShift};

  assign bus_if.in_ready  = inReady;
  assign bus_if.busy      = busyInt;
  assign bus_if.out_valid = outValid_q;
  assign bus_if.out_data  = outData_q;
endmodule

// File: tb/tb_fir_tdm_core.sv
// Directed bench: two cores (SHIFT=0 and SHIFT=6) share one stimulus stream and are
// compared every cycle against a behavioural FIR model, plus literal spot checks.
module tb_fir_tdm_core;
  localparam int TAPS    = 4;
  localparam int SHIFT_B = 6;

  logic clk, rstN, inValid, coefLoad, coefValid;
  logic signed [7:0] inData, coefData;

  int nChecks = 0;
  int nFail   = 0;
  int cyc     = 0;
  int capA[$];
  int capB[$];
  longint capT[$];
  longint acceptT;

  // Behavioural model state: coefficients, sample history and the one in-flight result.
  int coefM[TAPS];
  int histM[TAPS];
  bit pending;
  int acceptE;
  int yA, yB, lastA, lastB;

  fir_tdm_core_if #(.DATA_W(8), .COEF_W(8), .OUT_W(11)) ifA ();
  fir_tdm_core_if #(.DATA_W(8), .COEF_W(8), .OUT_W(11)) ifB ();

  assign ifA.in_valid   = inValid;
  assign ifA.in_data    = inData;
  assign ifA.coef_load  = coefLoad;
  assign ifA.coef_valid = coefValid;
  assign ifA.coef_data  = coefData;
  assign ifB.in_valid   = inValid;
  assign ifB.in_data    = inData;
  assign ifB.coef_load  = coefLoad;
  assign ifB.coef_valid = coefValid;
  assign ifB.coef_data  = coefData;

  fir_tdm_core #(.DATA_W(8), .COEF_W(8), .TAPS(TAPS), .OUT_W(11), .SHIFT(0)) dutA (
    .clk(clk), .rst_n(rstN), .bus_if(ifA));
  fir_tdm_core #(.DATA_W(8), .COEF_W(8), .TAPS(TAPS), .OUT_W(11), .SHIFT(SHIFT_B)) dutB (
    .clk(clk), .rst_n(rstN), .bus_if(ifB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int clampOut(input int v);
    if (v > 1023)  return 1023;
    if (v < -1024) return -1024;
    return v;
  endfunction

  function automatic void resetModel();
    for (int k = 0; k < TAPS; k++) begin
      coefM[k] = 0;
      histM[k] = 0;
    end
    coefM[0] = 1;
    pending  = 1'b0;
    acceptE  = -100;
    lastA    = 0;
    lastB    = 0;
  endfunction

  function automatic int capAt(input bit fromB, input int i);
    if (fromB) return (i < capB.size()) ? capB[i] : -99999;
    return (i < capA.size()) ? capA[i] : -99999;
  endfunction

  function automatic longint timeAt(input int i);
    return (i < capT.size()) ? capT[i] : 64'd0;
  endfunction

  // Accept edge E: busy on the cycles after edges E..E+TAPS, result pulse after E+TAPS+1.
  always @(negedge clk) begin
    bit busyExp, validExp, readyExp;
    int sum;
    cyc = cyc + 1;
    if (!rstN) begin
      resetModel();
      checkOutput("A in_ready in reset", int'(ifA.in_ready), 0);
      checkOutput("A busy in reset", int'(ifA.busy), 0);
      checkOutput("A out_valid in reset", int'(ifA.out_valid), 0);
      checkOutput("A out_data in reset", int'(ifA.out_data), 0);
      checkOutput("B out_valid in reset", int'(ifB.out_valid), 0);
      checkOutput("B out_data in reset", int'(ifB.out_data), 0);
    end else begin
      busyExp  = pending && (cyc >= acceptE) && (cyc <= acceptE + TAPS);
      validExp = pending && (cyc == acceptE + TAPS + 1);
      readyExp = !busyExp && !coefLoad;
      if (validExp) begin
        lastA = yA;
        lastB = yB;
      end
      checkOutput("A in_ready", int'(ifA.in_ready), int'(readyExp));
      checkOutput("A busy", int'(ifA.busy), int'(busyExp));
      checkOutput("A out_valid", int'(ifA.out_valid), int'(validExp));
      checkOutput("A out_data", int'(ifA.out_data), lastA);
      checkOutput("B in_ready", int'(ifB.in_ready), int'(readyExp));
      checkOutput("B busy", int'(ifB.busy), int'(busyExp));
      checkOutput("B out_valid", int'(ifB.out_valid), int'(validExp));
      checkOutput("B out_data", int'(ifB.out_data), lastB);
      if (validExp) pending = 1'b0;
      if (ifA.out_valid === 1'b1) begin
        capA.push_back(int'(ifA.out_data));
        capT.push_back($time);
      end
      if (ifB.out_valid === 1'b1) capB.push_back(int'(ifB.out_data));
      // Effects of the coming edge: a coefficient load in idle, or a sample acceptance.
      if (!busyExp && coefLoad) begin
        for (int k = 0; k < TAPS; k++) histM[k] = 0;
        if (coefValid) begin
          for (int k = 0; k < TAPS - 1; k++) coefM[k] = coefM[k+1];
          coefM[TAPS-1] = int'(coefData);
        end
      end else if (readyExp && inValid) begin
        for (int k = TAPS - 1; k > 0; k--) histM[k] = histM[k-1];
        histM[0] = int'(inData);
        sum = 0;
        for (int k = 0; k < TAPS; k++) sum += histM[k] * coefM[k];
        yA = clampOut(sum);
        yB = clampOut(sum >>> SHIFT_B);
        pending = 1'b1;
        acceptE = cyc + 1;
      end
    end
  end

  task automatic applyStimulus(input int d, input bit holdValid);
    int budget = 0;
    inValid = 1'b1;
    inData  = 8'(d);
    while (budget < 40) begin
      @(negedge clk);
      if (ifA.in_ready === 1'b1) break;
      budget++;
    end
    if (budget >= 40) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL accept timeout: got no in_ready in %0d cycles, expected acceptance", budget);
      inValid = 1'b0;
      return;
    end
    @(posedge clk);
    acceptT = $time;
    #1;
    if (!holdValid) inValid = 1'b0;
  endtask

  task automatic loadCoefs(input int w[TAPS], input int n);
    coefLoad = 1'b1;
    for (int i = 0; i < n; i++) begin
      coefValid = 1'b1;
      coefData  = 8'(w[i]);
      @(posedge clk);
      #1;
    end
    coefValid = 1'b0;
    coefLoad  = 1'b0;
  endtask

  task automatic waitOutputs(input int n);
    int budget = 0;
    while ((capA.size() < n || capB.size() < n) && budget < 60) begin
      @(posedge clk);
      budget++;
    end
    if (budget >= 60) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL output timeout: got %0d outputs, expected %0d", capA.size(), n);
    end
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    longint tAcc;
    rstN = 1'b0; inValid = 1'b0; inData = '0;
    coefLoad = 1'b0; coefValid = 1'b0; coefData = '0;
    @(posedge clk);
    #2;
    checkOutput("reset in_ready", int'(ifA.in_ready), 0);
    checkOutput("reset busy", int'(ifA.busy), 0);
    checkOutput("reset out_valid", int'(ifA.out_valid), 0);
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;

    // Passthrough after reset, including the accept-to-pulse latency.
    base = capA.size();
    applyStimulus(5, 1'b0);
    tAcc = acceptT;
    waitOutputs(base + 1);
    checkOutput("passthrough 5", capAt(0, base), 5);
    checkOutput("latency to out_valid sample", int'(timeAt(base) - tAcc), 55);
    applyStimulus(-7, 1'b0);
    waitOutputs(base + 2);
    checkOutput("passthrough -7", capAt(0, base + 1), -7);
    checkOutput("shift6 of -7", capAt(1, base + 1), -1);

    // Impulse response with coefficients 1,2,3,4.
    loadCoefs('{1, 2, 3, 4}, 4);
    base = capA.size();
    applyStimulus(1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1'b0);
    waitOutputs(base + 5);
    checkOutput("impulse y0", capAt(0, base), 1);
    checkOutput("impulse y1", capAt(0, base + 1), 2);
    checkOutput("impulse y2", capAt(0, base + 2), 3);
    checkOutput("impulse y3", capAt(0, base + 3), 4);
    checkOutput("impulse y4", capAt(0, base + 4), 0);

    // Saturation high and low, and the shifted core.
    loadCoefs('{127, 127, 127, 127}, 4);
    base = capA.size();
    for (int i = 0; i < 4; i++) applyStimulus(127, 1'b0);
    waitOutputs(base + 4);
    checkOutput("sat high", capAt(0, base + 3), 1023);
    checkOutput("shift6 first", capAt(1, base), 252);
    checkOutput("shift6 high", capAt(1, base + 3), 1008);
    base = capA.size();
    for (int i = 0; i < 4; i++) applyStimulus(-128, 1'b0);
    waitOutputs(base + 4);
    checkOutput("sat low", capAt(0, base + 3), -1024);
    checkOutput("shift6 low", capAt(1, base + 3), -1016);

    // Back-pressure: in_valid stays high across the ramp.
    loadCoefs('{1, 0, 0, 0}, 4);
    base = capA.size();
    applyStimulus(1, 1'b1);
    applyStimulus(2, 1'b1);
    applyStimulus(3, 1'b0);
    waitOutputs(base + 3);
    checkOutput("ramp y0", capAt(0, base), 1);
    checkOutput("ramp y1", capAt(0, base + 1), 2);
    checkOutput("ramp y2", capAt(0, base + 2), 3);
    checkOutput("ramp spacing 1", int'(timeAt(base + 1) - timeAt(base)), 60);
    checkOutput("ramp spacing 2", int'(timeAt(base + 2) - timeAt(base + 1)), 60);

    // Load requested while the MAC is busy only lands once the core is idle.
    base = capA.size();
    applyStimulus(10, 1'b0);
    @(posedge clk);
    #1;
    coefLoad = 1'b1; coefValid = 1'b1; coefData = 8'sd9;
    repeat (3) begin @(posedge clk); #1; end
    coefValid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    loadCoefs('{2, 0, 0, 0}, 4);
    waitOutputs(base + 1);
    checkOutput("in-flight keeps old coefs", capAt(0, base), 10);
    applyStimulus(6, 1'b0);
    waitOutputs(base + 2);
    checkOutput("new coefs apply", capAt(0, base + 1), 12);

    // Partial load: one strobe leaves c = {0,0,0,3}.
    loadCoefs('{3, 0, 0, 0}, 1);
    base = capA.size();
    applyStimulus(7, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0);
    waitOutputs(base + 4);
    checkOutput("partial y0", capAt(0, base), 0);
    checkOutput("partial y3", capAt(0, base + 3), 21);

    // Asynchronous reset in the second MAC cycle.
    base = capA.size();
    applyStimulus(9, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("busy before reset", int'(ifA.busy), 1);
    #1 rstN = 1'b0;
    #1;
    checkOutput("async busy", int'(ifA.busy), 0);
    checkOutput("async out_valid", int'(ifA.out_valid), 0);
    checkOutput("async in_ready", int'(ifA.in_ready), 0);
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    applyStimulus(3, 1'b0);
    waitOutputs(base + 1);
    checkOutput("passthrough after reset", capAt(0, base), 3);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end
endmodule
